// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: programs N/M/C0/K through the Avalon-MM
// reconfig core, starts the update, polls status and then waits for lock.
module pll_reconfig_ctrl #(
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_n_hi,
  input  logic [7:0]  cfg_n_lo,
  input  logic        cfg_n_bypass,
  input  logic [7:0]  cfg_m_hi,
  input  logic [7:0]  cfg_m_lo,
  input  logic [7:0]  cfg_c0_hi,
  input  logic [7:0]  cfg_c0_lo,
  input  logic [31:0] cfg_frac,
  output logic [5:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_TIMEOUT);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_TIMEOUT);
  localparam logic [4:0]    C0_SEL    = 5'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_FRAC, S_WR_START,
    S_POLL, S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            act_q, act_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]      sync_q;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [7:0]      n_hi_q, n_lo_q, m_hi_q, m_lo_q, c0_hi_q, c0_lo_q;
  logic            n_byp_q;
  logic [31:0]     frac_q;
  logic            lock_s, accept, is_xfer, xfer_ok, unused_rd;

  assign lock_s    = sync_q[1];
  assign accept    = (state_q == S_IDLE) && cfg_valid;
  assign is_xfer   = (state_q >= S_WR_MODE) && (state_q <= S_POLL);
  assign xfer_ok   = act_q && !avm_waitrequest;
  assign unused_rd = ^avm_readdata[31:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  // act_q is the strobe phase of a transfer state; a cleared act_q is the
  // mandatory idle cycle that separates consecutive transfers.
  always_comb begin
    state_d = state_q;
    act_d   = is_xfer && (!act_q || avm_waitrequest);
    case (state_q)
      S_IDLE:      if (cfg_valid) state_d = S_WR_MODE;
      S_WR_MODE:   if (xfer_ok) state_d = S_WR_N;
      S_WR_N:      if (xfer_ok) state_d = S_WR_M;
      S_WR_M:      if (xfer_ok) state_d = S_WR_C0;
      S_WR_C0:     if (xfer_ok) state_d = S_WR_FRAC;
      S_WR_FRAC:   if (xfer_ok) state_d = S_WR_START;
      S_WR_START:  if (xfer_ok) state_d = S_POLL;
      S_POLL: begin
        if (xfer_ok) begin
          if (avm_readdata[0])              state_d = S_WAIT_LOCK;
          else if (poll_cnt_q == POLL_LAST) state_d = S_ERR;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s)                       state_d = S_DONE;
        else if (lock_cnt_q == LOCK_LAST) state_d = S_ERR;
      end
      S_DONE:      state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready     = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    err           = err_q;
    err_code      = code_q;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    if (act_q) begin
      case (state_q)
        S_WR_MODE:  begin avm_write = 1'b1; avm_address = 6'd0; avm_writedata = 32'd1; end
        S_WR_N:     begin avm_write = 1'b1; avm_address = 6'd3;
                          avm_writedata = {15'd0, n_byp_q, n_hi_q, n_lo_q}; end
        S_WR_M:     begin avm_write = 1'b1; avm_address = 6'd4;
                          avm_writedata = {16'd0, m_hi_q, m_lo_q}; end
        S_WR_C0:    begin avm_write = 1'b1; avm_address = 6'd5;
                          avm_writedata = {9'd0, C0_SEL, 2'd0, c0_hi_q, c0_lo_q}; end
        S_WR_FRAC:  begin avm_write = 1'b1; avm_address = 6'd7; avm_writedata = frac_q; end
        S_WR_START: begin avm_write = 1'b1; avm_address = 6'd2; end
        S_POLL:     begin avm_read  = 1'b1; avm_address = 6'd1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    poll_cnt_d = '0;
    lock_cnt_d = '0;
    err_d      = err_q;
    code_d     = code_q;
    if (state_q == S_POLL) begin
      poll_cnt_d = poll_cnt_q;
      if (xfer_ok && !avm_readdata[0] && poll_cnt_q != POLL_MAX)
        poll_cnt_d = poll_cnt_q + PW'(1);
    end
    if (state_q == S_WAIT_LOCK) begin
      lock_cnt_d = lock_cnt_q;
      if (!lock_s && lock_cnt_q != LOCK_MAX)
        lock_cnt_d = lock_cnt_q + LW'(1);
    end
    if (accept) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end else if (state_d == S_ERR && state_q != S_ERR) begin
      err_d  = 1'b1;
      code_d = (state_q == S_POLL) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      poll_cnt_q <= '0;
      lock_cnt_q <= '0;
      err_q      <= 1'b0;
      code_q     <= '0;
      n_hi_q     <= '0;
      n_lo_q     <= '0;
      n_byp_q    <= 1'b0;
      m_hi_q     <= '0;
      m_lo_q     <= '0;
      c0_hi_q    <= '0;
      c0_lo_q    <= '0;
      frac_q     <= '0;
    end else begin
      sync_q     <= {sync_q[0], pll_locked};
      poll_cnt_q <= poll_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      err_q      <= err_d;
      code_q     <= code_d;
      if (accept) begin
        n_hi_q  <= cfg_n_hi;
        n_lo_q  <= cfg_n_lo;
        n_byp_q <= cfg_n_bypass;
        m_hi_q  <= cfg_m_hi;
        m_lo_q  <= cfg_m_lo;
        c0_hi_q <= cfg_c0_hi;
        c0_lo_q <= cfg_c0_lo;
        frac_q  <= cfg_frac;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: acts as the reconfig core and checks every
// cycle against a transaction-level model of the reconfiguration sequence.
module tb_pll_reconfig_ctrl;
  localparam int unsigned PT = 8;
  localparam int unsigned LT = 16;
  localparam int FAR = 32'h3fff_ffff;
  localparam int T_RAND = 0, T_NOM = 1, T_STALL = 2, T_POLLTO = 3, T_LOCKTO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_n_hi = '0, cfg_n_lo = '0, cfg_m_hi = '0, cfg_m_lo = '0;
  logic [7:0]  cfg_c0_hi = '0, cfg_c0_lo = '0;
  logic        cfg_n_bypass = 1'b0;
  logic [31:0] cfg_frac = '0;
  logic [5:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(.POLL_TIMEOUT(PT), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n_hi(cfg_n_hi), .cfg_n_lo(cfg_n_lo), .cfg_n_bypass(cfg_n_bypass),
    .cfg_m_hi(cfg_m_hi), .cfg_m_lo(cfg_m_lo), .cfg_c0_hi(cfg_c0_hi),
    .cfg_c0_lo(cfg_c0_lo), .cfg_frac(cfg_frac), .avm_address(avm_address),
    .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .pll_locked(pll_locked), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  typedef struct { bit rd; logic [5:0] a; logic [31:0] d; } xfer_t;
  xfer_t exp_q[$];

  // stimulus-owned
  int wmode = 0, tmode = T_RAND, plan_ok = 0, plan_lock = 0;
  // driver-owned
  int edge_n = 0, stall_left = 3;
  // monitor-owned
  int checks = 0, failures = 0;
  int rd_cnt = 0, seq_ok = 0, seq_lock = 0, seq_code = 0, obs_reads = 0;
  int lock_at = FAR, acc_edge = FAR, done_edge = FAR, err_edge = FAR, last_evt = -10;
  int acc_cnt = 0, end_cnt = 0, nom_idx = 0, m_stall = 0, wl_start = 0;
  bit exp_busy = 0, exp_err = 0;
  logic [1:0] exp_code = '0;
  logic p_wr = 0, p_rd = 0, p_wait = 0, p_err = 0;
  logic [5:0] p_addr = '0;
  logic [31:0] p_wdata = '0;

  logic [5:0]  nom_a [0:6] = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2, 6'd1};
  logic [31:0] nom_d [0:6] = '{32'h1, 32'h0001_0000, 32'h0505, 32'h1919,
                               32'h0CCC_CCCD, 32'h0, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reconfig-core responder: waitrequest, status word and lock line
  always @(posedge clk) begin : drv
    logic [31:0] rdw;
    edge_n = edge_n + 1;
    #1;
    case (wmode)
      0: avm_waitrequest = 1'b0;
      1: avm_waitrequest = ($urandom_range(0, 2) == 0);
      2: begin
        if (avm_write && avm_address == 6'd4 && stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else avm_waitrequest = 1'b0;
        if (cfg_ready) stall_left = 3;
      end
      default: avm_waitrequest = avm_write && (avm_address == 6'd5);
    endcase
    rdw = $urandom();
    rdw[0] = (rd_cnt >= seq_ok);
    avm_readdata = rdw;
    pll_locked = (edge_n >= lock_at);
  end

  always @(negedge clk) begin : mon
    xfer_t x;
    int n, e;
    n = edge_n;
    if (rst) begin
      exp_q.delete();
      exp_busy = 0; exp_err = 0; exp_code = '0;
      done_edge = FAR; err_edge = FAR; acc_edge = FAR; lock_at = FAR; last_evt = -10;
      chk("rst_busy", busy, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_read", avm_read, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_done", done, 0);
      chk("rst_err", {err, err_code}, 0);
      p_wr = 0; p_rd = 0; p_wait = 0; p_err = 0;
    end else begin
      if (n == acc_edge) begin exp_busy = 1; exp_err = 0; exp_code = '0; end
      if (n == err_edge) begin exp_err = 1; exp_code = 2'(seq_code); end
      if (n == done_edge + 1 || n == err_edge + 1) begin
        exp_busy = 0;
        end_cnt++;
        chk("queue_empty", exp_q.size(), 0);
      end
      chk("busy", busy, exp_busy);
      chk("cfg_ready", cfg_ready, !exp_busy);
      chk("done", done, n == done_edge);
      chk("err", err, exp_err);
      chk("err_code", err_code, exp_code);
      chk("wr_and_rd", avm_write & avm_read, 0);
      if ((p_wr || p_rd) && p_wait) begin
        chk("hold_strobe", {avm_write, avm_read}, {p_wr, p_rd});
        chk("hold_addr", avm_address, p_addr);
        chk("hold_data", avm_writedata, p_wdata);
      end
      if (n == last_evt + 1) chk("gap", avm_write | avm_read, 0);
      else if (n == last_evt + 2 && exp_q.size() > 0)
        chk("start", {avm_write, avm_read}, exp_q[0].rd ? 2'b01 : 2'b10);
      else if (exp_q.size() == 0) chk("no_xfer", avm_write | avm_read, 0);
      if (done && tmode == T_NOM) chk("nom_count", nom_idx, 7);
      if (err && !p_err) begin
        if (tmode == T_POLLTO) begin
          chk("pollto_reads", obs_reads, 8);
          chk("pollto_code", err_code, 2'b01);
        end
        if (tmode == T_LOCKTO) begin
          chk("lockto_cycles", n - wl_start, 16);
          chk("lockto_code", err_code, 2'b10);
        end
      end
      if (tmode == T_STALL && avm_write && avm_address == 6'd4) m_stall++;
      if ((avm_write || avm_read) && !avm_waitrequest) begin
        e = n + 1;
        last_evt = n;
        if (avm_read) obs_reads++;
        if (exp_q.size() == 0) chk("extra_xfer", 1, 0);
        else begin
          x = exp_q.pop_front();
          chk("xfer_kind", avm_read, x.rd);
          chk("xfer_addr", avm_address, x.a);
          if (!x.rd) chk("xfer_data", avm_writedata, x.d);
          if (tmode == T_NOM && nom_idx < 7) begin
            chk("nom_addr", avm_address, nom_a[nom_idx]);
            if (!x.rd) chk("nom_data", avm_writedata, nom_d[nom_idx]);
            nom_idx++;
          end
          if (tmode == T_STALL && !x.rd && x.a == 6'd4) chk("m_stall_cycles", m_stall, 4);
          if (x.rd) begin
            if (rd_cnt >= seq_ok) begin
              wl_start = e;
              lock_at = e + seq_lock;
              // lock seen after 2 sync flops, then one decision edge
              if (seq_lock + 3 <= int'(LT)) done_edge = e + seq_lock + 3;
              else begin err_edge = e + int'(LT); seq_code = 2; end
            end else begin
              rd_cnt++;
              if (rd_cnt == int'(PT)) begin err_edge = e; seq_code = 1; end
            end
          end
        end
      end
      if (cfg_valid && cfg_ready) begin
        acc_edge = n + 1; last_evt = n;
        done_edge = FAR; err_edge = FAR; lock_at = FAR;
        rd_cnt = 0; obs_reads = 0; nom_idx = 0; m_stall = 0;
        seq_ok = plan_ok; seq_lock = plan_lock;
        acc_cnt++;
        exp_q.delete();
        exp_q.push_back('{0, 6'd0, 32'd1});
        exp_q.push_back('{0, 6'd3, {15'd0, cfg_n_bypass, cfg_n_hi, cfg_n_lo}});
        exp_q.push_back('{0, 6'd4, {16'd0, cfg_m_hi, cfg_m_lo}});
        exp_q.push_back('{0, 6'd5, {16'd0, cfg_c0_hi, cfg_c0_lo}});
        exp_q.push_back('{0, 6'd7, cfg_frac});
        exp_q.push_back('{0, 6'd2, 32'd0});
        for (int i = 0; i < ((plan_ok < int'(PT)) ? plan_ok + 1 : int'(PT)); i++)
          exp_q.push_back('{1, 6'd1, 32'd0});
      end
      p_wr = avm_write; p_rd = avm_read; p_wait = avm_waitrequest;
      p_addr = avm_address; p_wdata = avm_writedata; p_err = err;
    end
  end

  task automatic rand_cfg();
    cfg_n_hi = 8'($urandom); cfg_n_lo = 8'($urandom); cfg_n_bypass = 1'($urandom);
    cfg_m_hi = 8'($urandom); cfg_m_lo = 8'($urandom);
    cfg_c0_hi = 8'($urandom); cfg_c0_lo = 8'($urandom); cfg_frac = $urandom();
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 1000 && acc_cnt < target; i++) begin @(posedge clk); #1; end
    if (acc_cnt < target) begin
      $display("FAIL accept_timeout actual=%0d required=%0d", acc_cnt, target);
      $fatal(1, "no accept");
    end
  endtask

  task automatic wait_end(input int target);
    for (int i = 0; i < 2000 && end_cnt < target; i++) begin @(posedge clk); #1; end
    if (end_cnt < target) begin
      $display("FAIL end_timeout actual=%0d required=%0d", end_cnt, target);
      $fatal(1, "sequence did not finish");
    end
  endtask

  task automatic run_seq(input int ok, input int lk);
    int a0, e0;
    a0 = acc_cnt; e0 = end_cnt;
    plan_ok = ok; plan_lock = lk;
    cfg_valid = 1'b1;
    wait_acc(a0 + 1);
    cfg_valid = 1'b0;
    wait_end(e0 + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic nom_cfg();
    cfg_n_bypass = 1'b1; cfg_n_hi = 8'd0; cfg_n_lo = 8'd0;
    cfg_m_hi = 8'd5; cfg_m_lo = 8'd5; cfg_c0_hi = 8'd25; cfg_c0_lo = 8'd25;
    cfg_frac = 32'd214748365;
  endtask

  initial begin
    int a0, e0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    tmode = T_NOM; wmode = 0; nom_cfg();
    run_seq(0, 10);

    tmode = T_STALL; wmode = 2; rand_cfg();
    run_seq(0, 3);

    tmode = T_POLLTO; wmode = 0; rand_cfg();
    run_seq(100, 0);

    tmode = T_LOCKTO; wmode = 1; rand_cfg();
    run_seq(2, 1000);

    tmode = T_RAND; wmode = 0; rand_cfg();
    run_seq(1, 4);

    // reset while WR_C0 is stalled
    wmode = 3; rand_cfg();
    plan_ok = 0; plan_lock = 5;
    a0 = acc_cnt;
    cfg_valid = 1'b1;
    wait_acc(a0 + 1);
    cfg_valid = 1'b0;
    for (int i = 0; i < 100 && !(avm_write && avm_address == 6'd5); i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wmode = 0;
    @(posedge clk); #1;
    tmode = T_NOM; nom_cfg();
    run_seq(0, 10);

    // request held across a whole sequence
    tmode = T_RAND; wmode = 1; rand_cfg();
    a0 = acc_cnt; e0 = end_cnt;
    plan_ok = 1; plan_lock = 2;
    cfg_valid = 1'b1;
    wait_acc(a0 + 2);
    cfg_valid = 1'b0;
    wait_end(e0 + 2);
    repeat (2) @(posedge clk); #1;

    for (int k = 0; k < 16; k++) begin
      wmode = 1; rand_cfg();
      run_seq(int'($urandom_range(0, 9)), int'($urandom_range(0, 16)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 4096: max status-read attempts before poll-timeout error.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: max clk cycles waiting for lock after reconfig.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  input  1  block clock, also the Avalon-MM clock of the PLL reconfig core
- rst  input  1  async active-high reset
- cfg_valid  input  1  new configuration request
- cfg_ready  output  1  request accepted when cfg_valid & cfg_ready
- cfg_n_hi, cfg_n_lo  input  8 each  N counter high/low counts
- cfg_n_bypass  input  1  N counter bypass
- cfg_m_hi, cfg_m_lo  input  8 each  M counter high/low counts
- cfg_c0_hi, cfg_c0_lo  input  8 each  C0 counter high/low counts
- cfg_frac  input  32  M fractional value (K)
- avm_address  output  6  reconfig-core register address
- avm_write, avm_read  output  1 each  Avalon-MM strobes
- avm_writedata  output  32  write data
- avm_readdata  input  32  read data
- avm_waitrequest  input  1  slave stall
- pll_locked  input  1  PLL locked, asynchronous to clk
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky error flag
- err_code  output  2  01 poll timeout, 10 lock timeout

Function
REQ-005 cfg_ready SHALL be 1 only in IDLE; all cfg_* fields are registered on the accepting cycle, and cfg_valid is ignored while busy.
REQ-006 Accepting a request SHALL clear err and err_code.
REQ-007 States SHALL be IDLE -> WR_MODE -> WR_N -> WR_M -> WR_C0 -> WR_FRAC -> WR_START -> POLL -> WAIT_LOCK -> DONE -> IDLE. Either timeout goes to ERR -> IDLE.
REQ-008 Write addresses and data SHALL be:
- WR_MODE: addr 0, data 1 (polling mode)
- WR_N: addr 3, data {cfg_n_bypass at bit16, hi at [15:8], lo at [7:0]}
- WR_M: addr 4, data {hi[15:8], lo[7:0]}
- WR_C0: addr 5, data {select 0 at [22:18], hi[15:8], lo[7:0]}
- WR_FRAC: addr 7, data cfg_frac
- WR_START: addr 2, data 0
- All unused bits are 0.
REQ-009 While avm_waitrequest=1, avm_address, avm_write, avm_read and avm_writedata SHALL hold stable; a transfer completes on the first cycle with the strobe high and waitrequest=0.
REQ-010 Strobes SHALL deassert for exactly one cycle between consecutive transfers, and avm_write and avm_read SHALL never be high together.
REQ-011 POLL SHALL read addr 1. avm_readdata is sampled on the completing cycle. Bit0=1 advances to WAIT_LOCK; bit0=0 issues another read. POLL_TIMEOUT completed reads with bit0=0 go to ERR with err_code 01.
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer. WAIT_LOCK advances when the synchronized locked=1. After LOCK_TIMEOUT cycles without lock it goes to ERR with err_code 10.
REQ-013 DONE SHALL last one cycle with done=1. ERR SHALL last one cycle, setting err=1, which holds until the next accepted request.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Timeout counters SHALL clear on entry to their state and SHALL saturate, never wrapping.

Reset
REQ-016 rst SHALL immediately force IDLE and drive to 0:
- busy, done, err, err_code
- avm_write, avm_read, avm_address, avm_writedata
- all counters and synchronizer flops
REQ-017 cfg_ready SHALL be 1 in the first cycle after rst deasserts. Reset mid-transfer abandons the transfer with no replay.

Verification
REQ-018 Nominal sequence:
- Stimulus: n_bypass=1, n 0/0, m 5/5, c0 25/25, frac=214748365, waitrequest=0, status bit0=1 on the first read, locked after 10 cycles.
- Response: writes (0,1) (3,0x00010000) (4,0x0505) (5,0x1919) (7,0x0CCCCCCD) (2,0), one read of addr 1, one done pulse, err=0.
REQ-019 waitrequest=1 for 3 cycles on the WR_M transfer -> address 4 and data 0x0505 stable for 4 cycles, then sequencing continues.
REQ-020 Status bit0 never set, POLL_TIMEOUT=8 -> exactly 8 reads of addr 1, then err=1, err_code=01, no done pulse, cfg_ready=1.
REQ-021 locked never asserts, LOCK_TIMEOUT=16 -> err=1, err_code=10 after 16 cycles in WAIT_LOCK; next accepted request clears err.
REQ-022 rst pulsed during WR_C0 with waitrequest=1 -> avm_write=0 immediately, busy=0. A new request then restarts from WR_MODE.
REQ-023 cfg_valid held high during a busy sequence -> exactly one sequence runs, and the second is accepted only after return to IDLE.
